// File: rtl/vc_wr_chan_sched.sv
// ============================================================================
// Module   : vc_wr_chan_sched
// Purpose  : Write-channel scheduler for the vector cache data SRAM. It grants
//            at most one source per cycle, taking turns in round-robin order,
//            and never lets two commands occupy the same channel at once.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vc_wr_chan_sched_pkg;

  localparam int NSRC = 5;

  typedef struct packed {
    logic [4:0]  dest_ram_id;   // [2:0] channel id, [4:3] hash id
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } arb_out_req_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

module vc_wr_chan_sched
  import vc_wr_chan_sched_pkg::*;
#(
  parameter int CHANNEL = 8,
  parameter int BEATS   = 4,
  parameter int DLY_W   = 2,
  parameter int DLY_E   = 3,
  parameter int DLY_S   = 6,
  parameter int DLY_N   = 4,
  parameter int DLY_LF  = 8,
  parameter int RW      = max_of(max_of(max_of(DLY_W, DLY_E), max_of(DLY_S, DLY_N)), DLY_LF) + BEATS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSRC-1:0]     req_vld,
  input  arb_out_req_t        req_pld [NSRC],
  output logic [NSRC-1:0]     req_rdy,
  output logic                out_vld,
  output logic [2:0]          out_src,
  output arb_out_req_t        out_pld,
  output logic [CHANNEL-1:0]  chan_busy
);

  localparam int CH_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

  function automatic int src_dly(input int i);
    case (i)
      0:       return DLY_W;
      1:       return DLY_E;
      2:       return DLY_S;
      3:       return DLY_N;
      default: return DLY_LF;
    endcase
  endfunction

  logic [RW-1:0]   r_resv     [CHANNEL];
  logic [RW-1:0]   w_resv_nxt [CHANNEL];
  logic [2:0]      r_ptr;
  logic [NSRC-1:0] w_elig;
  logic [RW-1:0]   w_mask     [NSRC];
  logic [CH_W-1:0] w_ch       [NSRC];
  logic            w_gnt_vld;
  logic [2:0]      w_gnt_src;

  // A source is eligible only if its whole future window on its channel is free.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    localparam int D = src_dly(i);
    assign w_ch[i]   = req_pld[i].dest_ram_id[CH_W-1:0];
    assign w_mask[i] = RW'({BEATS{1'b1}}) << (D - 1);
    assign w_elig[i] = req_vld[i] && (r_resv[w_ch[i]][D +: BEATS] == '0);
  end

  always_comb begin : p_arb
    logic [3:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_src = '0;
    idx       = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = 4'(r_ptr) + 4'(k);
      if (idx >= 4'(NSRC)) idx = idx - 4'(NSRC);
      if (!w_gnt_vld && w_elig[idx[2:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_src = idx[2:0];
      end
    end
    if (rst) w_gnt_vld = 1'b0;
  end

  always_comb begin
    req_rdy = '0;
    if (w_gnt_vld) req_rdy[w_gnt_src] = 1'b1;
  end

  // Reservation bit k of a channel is shifted to k-1 each cycle; the granted
  // window lands one position early because the shift happens in the same step.
  always_comb begin
    for (int c = 0; c < CHANNEL; c++) begin
      w_resv_nxt[c] = r_resv[c] >> 1;
      if (w_gnt_vld && (w_ch[w_gnt_src] == CH_W'(c)))
        w_resv_nxt[c] = w_resv_nxt[c] | w_mask[w_gnt_src];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL; c++) r_resv[c] <= '0;
      r_ptr     <= '0;
      out_vld   <= 1'b0;
      out_src   <= '0;
      out_pld   <= '0;
      chan_busy <= '0;
    end else begin
      for (int c = 0; c < CHANNEL; c++) begin
        r_resv[c]    <= w_resv_nxt[c];
        chan_busy[c] <= w_resv_nxt[c][0];
      end
      out_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        out_src <= w_gnt_src;
        out_pld <= req_pld[w_gnt_src];
        r_ptr   <= (w_gnt_src == 3'(NSRC - 1)) ? 3'd0 : w_gnt_src + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vc_wr_chan_sched.sv
// Testbench for vc_wr_chan_sched: directed scenarios followed by random traffic,
// checked every cycle against an absolute-time channel occupancy model.
`default_nettype none

module tb_vc_wr_chan_sched;
  import vc_wr_chan_sched_pkg::*;

  localparam int NS    = 5;
  localparam int NCH   = 8;
  localparam int BEATS = 4;
  localparam int MAXC  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NS-1:0] req_vld = '0;
  arb_out_req_t  pld [NS];
  logic [NS-1:0] req_rdy;
  logic          out_vld;
  logic [2:0]    out_src;
  arb_out_req_t  out_pld;
  logic [NCH-1:0] chan_busy;

  vc_wr_chan_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_pld   (pld),
    .req_rdy   (req_rdy),
    .out_vld   (out_vld),
    .out_src   (out_src),
    .out_pld   (out_pld),
    .chan_busy (chan_busy)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy per channel per absolute cycle.
  bit           occ [NCH][MAXC];
  int           cyc;
  int           ptr_m;
  logic         exp_vld;
  logic [2:0]   exp_src;
  arb_out_req_t exp_pld;
  bit           hold_vld;
  int           errors;
  int           checks;

  function automatic int dly(input int s);
    case (s)
      0:       return 2;
      1:       return 3;
      2:       return 6;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < NS; k++) begin
      int s;
      int ch;
      bit free;
      s = (ptr_m + k) % NS;
      if (req_vld[s]) begin
        ch   = int'(pld[s].dest_ram_id[2:0]);
        free = 1'b1;
        for (int b = 0; b < BEATS; b++)
          if (occ[ch][cyc + dly(s) + b]) free = 1'b0;
        if (free) return s;
      end
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < MAXC; t++) occ[c][t] = 1'b0;
    ptr_m   = 0;
    exp_vld = 1'b0;
    exp_src = '0;
    exp_pld = '0;
  endtask

  // Call at posedge+1; reset is asserted mid-cycle and released at posedge+1.
  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    #1;
    chk("rst_out_vld",   64'(out_vld),   64'd0);
    chk("rst_out_src",   64'(out_src),   64'd0);
    chk("rst_out_pld",   64'(out_pld),   64'd0);
    chk("rst_chan_busy", 64'(chan_busy), 64'd0);
    chk("rst_req_rdy",   64'(req_rdy),   64'd0);
    clear_model();
    repeat (ncyc) @(posedge clk);
    #1 rst = 1'b0;
    cyc += ncyc;
  endtask

  task automatic set_req(input int s, input int ch);
    pld[s].dest_ram_id = {2'($urandom), 3'(ch)};
    pld[s].addr        = 10'($urandom);
    pld[s].wdata       = $urandom;
    pld[s].wmask       = 4'($urandom);
    req_vld[s]         = 1'b1;
  endtask

  // want[5] set means req_rdy must also equal the directed value want[4:0].
  task automatic step(input logic [5:0] want);
    int         w;
    logic [4:0] er;
    logic [7:0] eb;
    @(negedge clk);
    w  = model_winner();
    er = (w >= 0) ? 5'(1 << w) : 5'd0;
    for (int c = 0; c < NCH; c++) eb[c] = occ[c][cyc];
    chk("req_rdy",   64'(req_rdy),   64'(er));
    if (want[5]) chk("req_rdy_directed", 64'(req_rdy), 64'(want[4:0]));
    chk("chan_busy", 64'(chan_busy), 64'(eb));
    chk("out_vld",   64'(out_vld),   64'(exp_vld));
    chk("out_src",   64'(out_src),   64'(exp_src));
    chk("out_pld",   64'(out_pld),   64'(exp_pld));
    @(posedge clk);
    exp_vld = (w >= 0);
    if (w >= 0) begin
      for (int b = 0; b < BEATS; b++)
        occ[int'(pld[w].dest_ram_id[2:0])][cyc + dly(w) + b] = 1'b1;
      ptr_m   = (w + 1) % NS;
      exp_src = 3'(w);
      exp_pld = pld[w];
    end
    cyc++;
    #1;
    if (w >= 0 && !hold_vld) req_vld[w] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(6'd0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    hold_vld = 1'b0;
    for (int s = 0; s < NS; s++) pld[s] = '0;
    clear_model();
    #6;
    do_reset(2);

    // Single W request on channel 3
    idle(2);
    set_req(0, 3);
    step({1'b1, 5'b00001});
    idle(7);

    // Conflict on channel 3, S on channel 5 overtakes the blocked E
    set_req(0, 3);
    step({1'b1, 5'b00001});
    set_req(1, 3);
    set_req(2, 5);
    step({1'b1, 5'b00100});
    step({1'b1, 5'b00000});
    step({1'b1, 5'b00010});
    idle(12);

    // Reset while channel 3 is reserved, then a blocked W wins right after
    set_req(0, 3);
    step({1'b1, 5'b00001});
    idle(2);
    set_req(0, 3);
    do_reset(2);
    step({1'b1, 5'b00001});
    idle(7);

    // Round robin with every source on its own channel
    do_reset(1);
    hold_vld = 1'b1;
    for (int s = 0; s < NS; s++) set_req(s, s);
    step({1'b1, 5'b00001});
    step({1'b1, 5'b00010});
    step({1'b1, 5'b00100});
    step({1'b1, 5'b01000});
    step({1'b1, 5'b10000});
    step({1'b1, 5'b00001});
    hold_vld = 1'b0;
    req_vld  = '0;
    idle(14);

    // Linefill window on channel 0 and a W that must wait for it
    set_req(4, 0);
    step({1'b1, 5'b10000});
    idle(5);
    set_req(0, 0);
    repeat (4) step({1'b1, 5'b00000});
    step({1'b1, 5'b00001});
    idle(12);

    // Random traffic on a few channels to force frequent conflicts
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < NS; s++)
        if (!req_vld[s] && $urandom_range(0, 2) == 0) set_req(s, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 149) == 0) do_reset(int'($urandom_range(1, 2)));
      step(6'd0);
    end
    req_vld = '0;
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
